irq_service_sequencer: RTL and testbench

- APB master that configures the 4-source interrupt controller after reset, then services its interrupt line.
- On interrupt it reads the status register, selects one pending source, writes that bit to the clear register, and presents the source ID to the CPU-side logic over a valid/ack handshake.
- Sits between the interrupt controller's APB slave port and the core.

---
 rtl/irq_service_sequencer_if.sv | 22 ++
 rtl/irq_service_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_irq_service_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_service_sequencer_if.sv
// APB link between the service sequencer (master) and the
// interrupt controller's register port (slave).
interface irq_service_sequencer_if;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   modport master (
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      output prdata_i, pready_i, pslverr_i
   );
endinterface

// File: rtl/irq_service_sequencer.sv
// Configures the 4-source interrupt controller over APB after reset, then
// services its interrupt line: read status, clear one source, hand its ID on.
module irq_service_sequencer #(
   parameter logic [3:0]  MASK_INIT   = 4'hF,
   parameter logic [2:0]  THRESH_INIT = 3'd4,
   parameter logic [11:0] PRIO_INIT   = 12'h249,
   parameter int unsigned HOLDOFF     = 2
) (
   input  logic                           pclk_i,
   input  logic                           rst_n_i,
   input  logic                           enable_i,
   irq_service_sequencer_if.master        apb,
   input  logic                           interrupt_i,
   output logic                           irq_valid_o,
   output logic [1:0]                     irq_id_o,
   input  logic                           irq_ack_i,
   output logic                           cfg_done_o,
   output logic                           spurious_o,
   output logic                           err_o
);

   localparam logic [2:0] ST_CFG     = 3'd0;
   localparam logic [2:0] ST_WAIT    = 3'd1;
   localparam logic [2:0] ST_RD_STAT = 3'd2;
   localparam logic [2:0] ST_WR_CLR  = 3'd3;
   localparam logic [2:0] ST_PRESENT = 3'd4;
   localparam logic [2:0] ST_HOLD    = 3'd5;

   localparam logic [31:0] ADDR_STATUS   = 32'd1;
   localparam logic [31:0] ADDR_CLEAR    = 32'd2;
   localparam logic [31:0] ADDR_CFG_BASE = 32'd3;
   localparam logic [2:0]  CFG_LAST      = 3'd5;
   localparam logic [2:0]  HOLD_LAST     = 3'(HOLDOFF - 1);

   logic [2:0]  state;
   logic [2:0]  cfg_idx;
   logic [2:0]  hold_cnt;
   logic [1:0]  irq_id;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        irq_valid;
   logic        cfg_done;
   logic        spurious;
   logic        err;

   logic        xfer_state;
   logic        completing;
   logic [31:0] setup_addr;
   logic        setup_write;
   logic [31:0] setup_data;
   logic [31:0] cfg_data;
   logic [3:0]  pend;
   logic [1:0]  low_id;
   logic [3:0]  clr_mask;
   logic        unused_prdata;

   assign xfer_state    = (state == ST_CFG) || (state == ST_RD_STAT) || (state == ST_WR_CLR);
   assign completing    = psel && penable && apb.pready_i;
   assign pend          = apb.prdata_i[3:0] & MASK_INIT;
   assign clr_mask      = 4'b0001 << irq_id;
   assign unused_prdata = ^apb.prdata_i[31:4];

   always_comb begin
      cfg_data = 32'd0;
      case (cfg_idx)
         3'd0: cfg_data = {28'd0, MASK_INIT};
         3'd1: cfg_data = {29'd0, THRESH_INIT};
         3'd2: cfg_data = {29'd0, PRIO_INIT[2:0]};
         3'd3: cfg_data = {29'd0, PRIO_INIT[5:3]};
         3'd4: cfg_data = {29'd0, PRIO_INIT[8:6]};
         3'd5: cfg_data = {29'd0, PRIO_INIT[11:9]};
         default: cfg_data = 32'd0;
      endcase
   end

   // Lowest pending index wins; only meaningful when pend is non-zero.
   always_comb begin
      low_id = 2'd3;
      if (pend[0])      low_id = 2'd0;
      else if (pend[1]) low_id = 2'd1;
      else if (pend[2]) low_id = 2'd2;
   end

   always_comb begin
      setup_addr  = 32'd0;
      setup_write = 1'b0;
      setup_data  = 32'd0;
      case (state)
         ST_CFG: begin
            setup_addr  = ADDR_CFG_BASE + {29'd0, cfg_idx};
            setup_write = 1'b1;
            setup_data  = cfg_data;
         end
         ST_RD_STAT: setup_addr = ADDR_STATUS;
         ST_WR_CLR: begin
            setup_addr  = ADDR_CLEAR;
            setup_write = 1'b1;
            setup_data  = {28'd0, clr_mask};
         end
         default: ;
      endcase
   end

   // APB phase is carried by psel/penable themselves: idle, setup or access.
   // A transfer state always spends one idle cycle before its setup phase.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_CFG;
         cfg_idx   <= 3'd0;
         hold_cnt  <= 3'd0;
         irq_id    <= 2'd0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= 32'd0;
         pwdata    <= 32'd0;
         irq_valid <= 1'b0;
         cfg_done  <= 1'b0;
         spurious  <= 1'b0;
         err       <= 1'b0;
      end else if (enable_i) begin
         spurious <= 1'b0;
         if (completing) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= 32'd0;
            pwdata  <= 32'd0;
            if (apb.pslverr_i) err <= 1'b1;
         end else if (psel) begin
            penable <= 1'b1;
         end else if (xfer_state) begin
            psel   <= 1'b1;
            paddr  <= setup_addr;
            pwrite <= setup_write;
            pwdata <= setup_data;
         end

         case (state)
            ST_CFG: begin
               if (completing) begin
                  if (cfg_idx == CFG_LAST) begin
                     cfg_done <= 1'b1;
                     state    <= ST_WAIT;
                  end else begin
                     cfg_idx <= cfg_idx + 3'd1;
                  end
               end
            end
            ST_WAIT: if (interrupt_i) state <= ST_RD_STAT;
            ST_RD_STAT: begin
               if (completing) begin
                  if (pend == 4'd0) begin
                     spurious <= 1'b1;
                     hold_cnt <= 3'd0;
                     state    <= ST_HOLD;
                  end else begin
                     irq_id <= low_id;
                     state  <= ST_WR_CLR;
                  end
               end
            end
            ST_WR_CLR: begin
               if (completing) begin
                  irq_valid <= 1'b1;
                  state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (irq_ack_i) begin
                  irq_valid <= 1'b0;
                  hold_cnt  <= 3'd0;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (hold_cnt == HOLD_LAST) state <= ST_WAIT;
               else                       hold_cnt <= hold_cnt + 3'd1;
            end
            default: state <= ST_CFG;
         endcase
      end
   end

   assign apb.psel_o    = psel;
   assign apb.penable_o = penable;
   assign apb.pwrite_o  = pwrite;
   assign apb.paddr_o   = paddr;
   assign apb.pwdata_o  = pwdata;
   assign irq_valid_o   = irq_valid;
   assign irq_id_o      = irq_id;
   assign cfg_done_o    = cfg_done;
   assign spurious_o    = spurious;
   assign err_o         = err;

endmodule

// File: tb/tb_irq_service_sequencer.sv
// Directed bench for irq_service_sequencer: configuration, servicing,
// stalls, spurious reads, slave errors, clock-enable freeze and reset.
module tb_irq_service_sequencer;

   logic       pclk_i = 1'b0;
   logic       rst_n_i;
   logic       enable_i;
   logic       interrupt_i;
   logic       irq_valid_o;
   logic [1:0] irq_id_o;
   logic       irq_ack_i;
   logic       cfg_done_o;
   logic       spurious_o;
   logic       err_o;

   int vectors     = 0;
   int miscompares = 0;

   irq_service_sequencer_if apb ();

   irq_service_sequencer dut (
      .pclk_i      (pclk_i),
      .rst_n_i     (rst_n_i),
      .enable_i    (enable_i),
      .apb         (apb),
      .interrupt_i (interrupt_i),
      .irq_valid_o (irq_valid_o),
      .irq_id_o    (irq_id_o),
      .irq_ack_i   (irq_ack_i),
      .cfg_done_o  (cfg_done_o),
      .spurious_o  (spurious_o),
      .err_o       (err_o)
   );

   always #5 pclk_i = ~pclk_i;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge pclk_i);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, " psel"}, 32'(apb.psel_o), 32'd0);
      check_output({tag, " penable"}, 32'(apb.penable_o), 32'd0);
      check_output({tag, " paddr"}, apb.paddr_o, 32'd0);
      check_output({tag, " pwdata"}, apb.pwdata_o, 32'd0);
   endtask

   task automatic check_setup(input string tag, input logic [31:0] addr, input logic wr, input logic [31:0] data);
      check_output({tag, " psel"}, 32'(apb.psel_o), 32'd1);
      check_output({tag, " penable"}, 32'(apb.penable_o), 32'd0);
      check_output({tag, " paddr"}, apb.paddr_o, addr);
      check_output({tag, " pwrite"}, 32'(apb.pwrite_o), 32'(wr));
      check_output({tag, " pwdata"}, apb.pwdata_o, data);
   endtask

   task automatic check_access(input string tag, input logic [31:0] addr, input logic [31:0] data);
      check_output({tag, " psel"}, 32'(apb.psel_o), 32'd1);
      check_output({tag, " penable"}, 32'(apb.penable_o), 32'd1);
      check_output({tag, " paddr"}, apb.paddr_o, addr);
      check_output({tag, " pwdata"}, apb.pwdata_o, data);
   endtask

   // Starts with the FSM in WAIT and interrupt_i high; ends one cycle
   // after the ack edge, with the FSM at the start of HOLD.
   task automatic run_service(input string tag, input logic [31:0] clr, input logic [1:0] id);
      tick(); check_idle({tag, " rd-idle"});
      tick(); check_setup({tag, " rd-setup"}, 32'd1, 1'b0, 32'd0);
      tick(); check_access({tag, " rd-access"}, 32'd1, 32'd0);
      tick(); check_idle({tag, " wr-idle"});
      tick(); check_setup({tag, " wr-setup"}, 32'd2, 1'b1, clr);
      tick(); check_access({tag, " wr-access"}, 32'd2, clr);
      tick();
      check_output({tag, " valid"}, 32'(irq_valid_o), 32'd1);
      check_output({tag, " id"}, 32'(irq_id_o), 32'(id));
      tick();
      check_output({tag, " valid-drop"}, 32'(irq_valid_o), 32'd0);
   endtask

   logic [31:0] cfg_addr [6] = '{32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
   logic [31:0] cfg_data [6] = '{32'hF, 32'h4, 32'h1, 32'h1, 32'h1, 32'h1};

   initial begin
      rst_n_i       = 1'b0;
      enable_i      = 1'b1;
      interrupt_i   = 1'b0;
      irq_ack_i     = 1'b0;
      apb.prdata_i  = 32'd0;
      apb.pready_i  = 1'b1;
      apb.pslverr_i = 1'b0;

      tick();
      tick();
      check_idle("reset");
      check_output("reset cfg_done", 32'(cfg_done_o), 32'd0);
      check_output("reset valid", 32'(irq_valid_o), 32'd0);
      check_output("reset err", 32'(err_o), 32'd0);
      check_output("reset spurious", 32'(spurious_o), 32'd0);
      rst_n_i = 1'b1;

      for (int i = 0; i < 6; i++) begin
         tick(); check_setup($sformatf("cfg%0d setup", i), cfg_addr[i], 1'b1, cfg_data[i]);
         tick(); check_access($sformatf("cfg%0d access", i), cfg_addr[i], cfg_data[i]);
         tick(); check_idle($sformatf("cfg%0d idle", i));
         check_output($sformatf("cfg%0d cfg_done", i), 32'(cfg_done_o), 32'(i == 5));
      end
      check_output("cfg err", 32'(err_o), 32'd0);

      interrupt_i  = 1'b1;
      irq_ack_i    = 1'b1;
      apb.prdata_i = 32'h6;
      run_service("svc1", 32'h2, 2'd1);
      apb.prdata_i = 32'h4;
      tick();
      tick();
      run_service("svc2", 32'h4, 2'd2);
      interrupt_i = 1'b0;
      tick();
      tick();
      tick(); check_idle("quiet wait");

      interrupt_i  = 1'b1;
      apb.prdata_i = 32'h8;
      tick(); check_idle("stall rd-idle");
      tick(); check_setup("stall rd-setup", 32'd1, 1'b0, 32'd0);
      apb.pready_i = 1'b0;
      apb.prdata_i = 32'h1;
      tick(); check_access("stall access0", 32'd1, 32'd0);
      tick(); check_access("stall access1", 32'd1, 32'd0);
      tick(); check_access("stall access2", 32'd1, 32'd0);
      tick(); check_access("stall access3", 32'd1, 32'd0);
      apb.pready_i = 1'b1;
      apb.prdata_i = 32'h8;
      tick(); check_idle("stall wr-idle");
      tick(); check_setup("stall wr-setup", 32'd2, 1'b1, 32'h8);
      tick(); check_access("stall wr-access", 32'd2, 32'h8);
      tick();
      check_output("stall valid", 32'(irq_valid_o), 32'd1);
      check_output("stall id", 32'(irq_id_o), 32'd3);
      interrupt_i = 1'b0;
      tick(); check_output("stall valid-drop", 32'(irq_valid_o), 32'd0);
      tick();
      tick();

      interrupt_i  = 1'b1;
      apb.prdata_i = 32'h0;
      tick(); check_idle("spur rd-idle");
      tick(); check_setup("spur rd-setup", 32'd1, 1'b0, 32'd0);
      tick(); check_access("spur rd-access", 32'd1, 32'd0);
      tick();
      check_output("spur pulse", 32'(spurious_o), 32'd1);
      check_idle("spur hold0");
      tick();
      check_output("spur pulse-end", 32'(spurious_o), 32'd0);
      check_idle("spur hold1");
      tick(); check_idle("spur wait");
      tick(); check_idle("spur reread-idle");
      tick(); check_setup("spur reread-setup", 32'd1, 1'b0, 32'd0);
      apb.prdata_i = 32'h1;
      tick(); check_access("spur reread-access", 32'd1, 32'd0);
      tick(); check_idle("err wr-idle");
      tick(); check_setup("err wr-setup", 32'd2, 1'b1, 32'h1);
      apb.pslverr_i = 1'b1;
      irq_ack_i     = 1'b0;
      tick(); check_access("err wr-access", 32'd2, 32'h1);
      tick();
      apb.pslverr_i = 1'b0;
      interrupt_i   = 1'b0;
      check_output("err set", 32'(err_o), 32'd1);
      check_output("err valid", 32'(irq_valid_o), 32'd1);
      check_output("err id", 32'(irq_id_o), 32'd0);
      tick();
      check_output("err sticky", 32'(err_o), 32'd1);
      check_output("no-ack valid held", 32'(irq_valid_o), 32'd1);

      rst_n_i = 1'b0;
      #1;
      check_output("midreset valid", 32'(irq_valid_o), 32'd0);
      check_output("midreset psel", 32'(apb.psel_o), 32'd0);
      check_output("midreset cfg_done", 32'(cfg_done_o), 32'd0);
      check_output("midreset err", 32'(err_o), 32'd0);
      tick();
      rst_n_i = 1'b1;
      tick(); check_setup("replay cfg0 setup", 32'h3, 1'b1, 32'hF);
      enable_i = 1'b0;
      tick(); check_setup("freeze0", 32'h3, 1'b1, 32'hF);
      tick(); check_setup("freeze1", 32'h3, 1'b1, 32'hF);
      enable_i = 1'b1;
      tick(); check_access("replay cfg0 access", 32'h3, 32'hF);
      tick(); check_idle("replay cfg0 idle");
      tick(); check_setup("replay cfg1 setup", 32'h4, 1'b1, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
